// File: rtl/sram_resp_512x56.sv
// Synchronous single-port 512x56 memory responder for the NCE/NWRT row/column protocol.
// Clears the array after reset, then serves one-cycle-latency reads with strobe, counters and error flag.
module sram_resp_512x56 #(
    parameter int              DW           = 56,
    parameter int              RAW          = 6,
    parameter int              CAW          = 3,
    parameter logic [DW-1:0]   INIT_VAL     = '0,
    parameter int              CLR_ON_RESET = 1,
    parameter int              CNTW         = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            nce,
    input  logic            nwrt,
    input  logic [RAW-1:0]  ra,
    input  logic [CAW-1:0]  ca,
    input  logic [DW-1:0]   din,
    output logic [DW-1:0]   dout,
    output logic            rvalid,
    output logic            ready,
    output logic [CNTW-1:0] rd_cnt,
    output logic [CNTW-1:0] wr_cnt,
    output logic            err
);

    // state   | meaning
    // ST_INIT | sweeping INIT_VAL through the array, accesses rejected
    // ST_RUN  | serving accesses (first cycle after a sweep-less reset still rejects)
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int AW    = RAW + CAW;
    localparam int DEPTH = 2 ** AW;

    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};
    localparam logic [0:0]      ST_RESET  = (CLR_ON_RESET != 0) ? ST_INIT : ST_RUN;

    logic [DW-1:0] mem [0:DEPTH-1];

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   init_addr_q, init_addr_d;
    logic            ready_q, ready_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            rvalid_q, rvalid_d;
    logic [CNTW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNTW-1:0] wr_cnt_q, wr_cnt_d;
    logic            err_q, err_d;

    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [DW-1:0]   mem_wd;
    logic [AW-1:0]   addr;
    logic            acc;

    assign addr = {ra, ca};
    assign acc  = ~nce;

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        ready_d     = ready_q;
        dout_d      = dout_q;
        rvalid_d    = 1'b0;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        mem_wa      = addr;
        mem_wd      = din;

        case (state_q)
            ST_INIT: begin
                mem_we      = 1'b1;
                mem_wa      = init_addr_q;
                mem_wd      = INIT_VAL;
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
                if (acc) err_d = 1'b1;
            end
            ST_RUN: begin
                if (!ready_q) begin
                    ready_d = 1'b1;
                    if (acc) err_d = 1'b1;
                end else if (acc) begin
                    if (!nwrt) begin
                        mem_we = 1'b1;
                        if (wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + 1'b1;
                    end else begin
                        dout_d   = mem[addr];
                        rvalid_d = 1'b1;
                        if (rd_cnt_q != CNT_MAX) rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // The array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_RESET;
            init_addr_q <= '0;
            ready_q     <= 1'b0;
            dout_q      <= '0;
            rvalid_q    <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            ready_q     <= ready_d;
            dout_q      <= dout_d;
            rvalid_q    <= rvalid_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            err_q       <= err_d;
        end
    end

    assign dout   = dout_q;
    assign rvalid = rvalid_q;
    assign ready  = ready_q;
    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
    assign err    = err_q;

endmodule

// File: doc/sram_resp_512x56.md
Name: sram_resp_512x56

Overview:
- Synchronous single-port 512x56 memory responder. It answers the active-low NCE/NWRT, row/column-addressed protocol driven by the multiply-accumulate memory controllers.
- Serves as a synthesizable drop-in for the hard SRAM macro in simulation and FPGA builds.
- Adds a post-reset clear sweep, a ready flag, a read-valid strobe, access counters and a sticky protocol-error flag.

Parameters:
- DW, 56, data word width.
- RAW, 6, row address width; rows = 2**RAW.
- CAW, 3, column address width; depth = 2**(RAW+CAW) = 512.
- INIT_VAL, 0, value written to every word by the post-reset sweep.
- CLR_ON_RESET, 1, 1 = run the init sweep after reset; 0 = skip it and go straight to RUN.
- CNTW, 16, access counter width.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- nce  input  1  chip enable, active low.
- nwrt  input  1  0 = write, 1 = read; only meaningful when nce=0.
- ra  input  RAW  row address.
- ca  input  CAW  column address; word address = {ra,ca}.
- din  input  DW  write data.
- dout  output  DW  registered read data.
- rvalid  output  1  one-cycle strobe; dout was updated by the previous edge.
- ready  output  1  high when accesses are accepted.
- rd_cnt  output  CNTW  accepted reads, saturating.
- wr_cnt  output  CNTW  accepted writes, saturating.
- err  output  1  sticky: an access was attempted while ready=0.

Behaviour:
- Reset (rstn=0, asynchronous, takes effect immediately without a clock edge):
  - dout=0, rvalid=0, ready=0, rd_cnt=0, wr_cnt=0, err=0.
  - FSM goes to INIT with init_addr=0, or to RUN if CLR_ON_RESET=0.
  - The memory array itself is never asynchronously reset.
- FSM states: INIT, RUN.
- INIT:
  - Each edge writes INIT_VAL to mem[init_addr], then init_addr increments.
  - The edge that writes address 511 moves the FSM to RUN and sets ready=1.
  - ready is therefore first high after the 512th edge following reset release.
  - If CLR_ON_RESET=0, ready=1 after the first edge following reset release.
- Access decode, sampled on the rising edge while in RUN:
  - nce=0, nwrt=0: write. mem[{ra,ca}] <= din; wr_cnt++ (saturating); dout unchanged; rvalid <= 0.
  - nce=0, nwrt=1: read. dout <= mem[{ra,ca}]; rvalid <= 1; rd_cnt++ (saturating). Read latency is one edge.
  - nce=1: idle. No array change; dout holds; rvalid <= 0.
- dout holds its last read value indefinitely; writes never alter dout, even to the last-read address.
- Back-to-back reads give rvalid high continuously, with a new dout each cycle.
- Read after write to the same address on the next edge returns the new data (no hazard; single port).
- Access with nce=0 while ready=0 (INIT):
  - Ignored: no array write, no dout change, counters unchanged.
  - err <= 1; it stays 1 until reset.
- Counters saturate at 2**CNTW-1 and never wrap.
- Reset asserted mid-sweep or mid-access: outputs clear immediately, and the sweep restarts from address 0 after release.
- Address inputs are full-width; every {ra,ca} combination is a valid location (no out-of-range case).

Test Plan:
- Release rstn, count edges -> ready=0 through edge 511, ready=1 after edge 512; then read {ra=6'h3F,ca=3'h7} -> next cycle rvalid=1, dout=0.
- In RUN, write din=56'h12_3456_789A_BCDE at ra=6'h05, ca=3'h3; read the same address on the next edge -> rvalid=1 one cycle later, dout=56'h12_3456_789A_BCDE, wr_cnt=1, rd_cnt=1; drive nce=1 for 3 cycles -> dout holds, rvalid=0.
- nce=1, nwrt=0, din=56'hFF..FF at ra=6'h05, ca=3'h3, then read it -> dout still 56'h12_3456_789A_BCDE, wr_cnt unchanged.
- Drive nce=0, nwrt=0 at edge 10 of INIT -> err=1 and stays 1; wr_cnt=0; after ready, that address reads INIT_VAL.
- Issue 65540 consecutive reads -> rd_cnt=16'hFFFF with no wrap; rvalid high every cycle.
- With dout nonzero, pull rstn low between edges -> dout=0, rvalid=0, ready=0, counters=0 immediately; after release and the 512-edge sweep, the previously written word reads 0.
